// File: rtl/disp_mux_7seg.sv
// ============================================================================
// Module   : disp_mux_7seg
// Purpose  : Four-digit multiplexed 7-segment driver with BCD decode and
//            per-digit decimal points. LEADING_ZERO_BLANK_EN enables
//            leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_mux_7seg #(
    parameter int REFRESH_BITS = 18
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [3:0] dp,
    output logic [3:0] an,
    output logic [7:0] sseg
);

    localparam logic [REFRESH_BITS-1:0] Q_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    logic [REFRESH_BITS-1:0] q;
    logic [1:0]              sel;
    logic [3:0]              digit;
    logic [3:0]              an_next;
    logic                    dp_bit;
    logic [6:0]              seg_dec;
    logic [6:0]              seg_out;

    assign sel    = q[REFRESH_BITS-1:REFRESH_BITS-2];
    assign dp_bit = dp[sel];

    always_comb begin
        digit   = d0;
        an_next = 4'b1110;
        case (sel)
            2'd0: begin digit = d0; an_next = 4'b1110; end
            2'd1: begin digit = d1; an_next = 4'b1101; end
            2'd2: begin digit = d2; an_next = 4'b1011; end
            2'd3: begin digit = d3; an_next = 4'b0111; end
            default: begin digit = d0; an_next = 4'b1110; end
        endcase
    end

    // Active-low gfedcba; anything outside 0..9 shows a dash.
    always_comb begin
        case (digit)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'b0111111;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic blank3;
    logic blank2;
    logic blank1;
    logic blank;

    // A digit is blank only when it and every more significant digit are zero.
    assign blank3 = (d3 == 4'd0);
    assign blank2 = blank3 && (d2 == 4'd0);
    assign blank1 = blank2 && (d1 == 4'd0);

    always_comb begin
        case (sel)
            2'd3:    blank = blank3;
            2'd2:    blank = blank2;
            2'd1:    blank = blank1;
            default: blank = 1'b0;
        endcase
    end

    assign seg_out = blank ? 7'b1111111 : seg_dec;
`else
    assign seg_out = seg_dec;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q    <= '0;
            an   <= 4'b1111;
            sseg <= 8'hFF;
        end else begin
            q    <= q + Q_ONE;
            an   <= an_next;
            sseg <= {~dp_bit, seg_out};
        end
    end

endmodule

`default_nettype wire

// File: doc/disp_mux_7seg.md
DISP_MUX_7SEG -- requirements
Module: disp_mux_7seg

Interface
REQ-001 The block SHALL have parameter REFRESH_BITS, default 18, the refresh counter width; legal range 4..32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all flops are rising-edge.
REQ-003 The block SHALL have port clr_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports d3, d2, d1, d0, input, 4 each, BCD digits from the upstream counter; d3 is the most significant.
REQ-005 The block SHALL have port dp, input, 4, per-digit decimal-point request (bit i belongs to digit di), active-high.
REQ-006 The block SHALL have port an, output, 4, digit anode enables, active-low (bit i drives digit di).
REQ-007 The block SHALL have port sseg, output, 8, segment cathodes, active-low; bit 7 is dp, bits 6..0 are g,f,e,d,c,b,a.

Function
REQ-008 The refresh counter q SHALL increment by 1 every clk and wrap from all-ones to 0 with no terminal hold.
REQ-009 The digit select sel SHALL be q[REFRESH_BITS-1:REFRESH_BITS-2], so each digit is held for 2^(REFRESH_BITS-2) cycles.
REQ-010 an SHALL be registered as follows: sel 0 -> 1110 (d0), sel 1 -> 1101 (d1), sel 2 -> 1011 (d2), sel 3 -> 0111 (d3).
REQ-011 Exactly one an bit SHALL be low at all times after the first post-reset clock edge.
REQ-012 sseg SHALL be registered in the same cycle as an, so the segment pattern always matches the enabled anode; latency from a sel change to the output is 1 clk.
REQ-013 Digit and dp inputs SHALL be sampled every clk, so a change on the currently selected digit appears on sseg 1 clk later without waiting for the next scan.
REQ-014 The BCD decode (active-low gfedcba) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-015 Non-BCD inputs 10..15 SHALL decode to a dash, g only = 0111111.
REQ-016 sseg[7] SHALL be the inverse of dp[sel].

Reset
REQ-017 While clr_n is low, q SHALL be 0, an SHALL be 1111 and sseg SHALL be 11111111 (all dark), regardless of clk.
REQ-018 Assertion of clr_n mid-scan SHALL take effect immediately (asynchronously) and blank the display.
REQ-019 After clr_n deasserts, the first rising clk edge SHALL load an=1110 and decode(d0); the scan then restarts at digit 0.

Configuration
REQ-020 Macro LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
REQ-021 With LEADING_ZERO_BLANK_EN defined:
- d3 is blanked if d3==0.
- d2 is blanked if d3==0 and d2==0.
- d1 is blanked if d3, d2 and d1 are all 0.
- d0 is never blanked.
- A blanked digit drives sseg[6:0]=1111111; its anode still scans; dp is unaffected.
REQ-022 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always be decoded, including leading zeros, and the blanking logic SHALL be absent from the netlist.

Verification (REFRESH_BITS=4, so each digit lasts 4 clk)
REQ-023 clr_n low, then released, with d3..d0=1,2,3,4 and dp=0000 -> cycle 1: an=1110, sseg=10011001; cycle 5: an=1101, sseg=10110000; cycle 9: an=1011, sseg=10100100; cycle 13: an=0111, sseg=11111001; cycle 17: an=1110 again (wrap).
REQ-024 d0 changes from 4 to 9 while an=1110 -> sseg=10010000 one clk later, with no anode change.
REQ-025 d1=4'hC and dp=0010 -> while an=1101, sseg=00111111 (dash plus dp lit).
REQ-026 Digits 0,0,0,7 (d3..d0):
- With LEADING_ZERO_BLANK_EN: d3, d2, d1 slots give sseg=11111111 and the d0 slot gives 11111000.
- Without the macro: the zero slots give 11000000.
REQ-027 Digits 0,5,0,0 with LEADING_ZERO_BLANK_EN -> the d3 slot is blank and the d2, d1, d0 slots give 10010010, 11000000, 11000000 (interior zeros are not blanked).
REQ-028 Pulse clr_n low for 1 ns while an=1011 -> an=1111 and sseg=11111111 immediately; on the next clk after release, an=1110.
